// File: rtl/uart_word_tx_pkg.sv
// uart_word_tx_pkg: shared 8N1 frame constants and state encodings
// for the UART transmit/receive paths.
package uart_word_tx_pkg;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam int   DATA_BITS   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_BIT,
    S_DATA_BITS,
    S_STOP_BIT,
    S_NEXT_BYTE
  } tx_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_NEXT
  } word_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser, LSB first, registered tx.
// byte_done marks the last clock of the stop bit.
module uart_tx_byte
  import uart_word_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_start,
  input  logic [7:0] byte_data,
  output logic       byte_busy,
  output logic       byte_done,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e      st;
  logic [CNT_W-1:0] cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     sh;
  logic           bit_end;

  assign bit_end   = (cnt == CNT_LAST);
  assign byte_busy = (st != S_IDLE);
  assign byte_done = (st == S_STOP_BIT) && bit_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      tx      <= STOP_LEVEL;
    end else begin
      unique case (st)
        S_IDLE: begin
          tx  <= STOP_LEVEL;
          cnt <= '0;
          if (byte_start) begin
            sh <= byte_data;
            tx <= START_LEVEL;
            st <= S_START_BIT;
          end
        end
        S_START_BIT: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= sh[0];
            st      <= S_DATA_BITS;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DATA_BITS: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              tx <= STOP_LEVEL;
              st <= S_STOP_BIT;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              sh      <= sh >> 1;
              tx      <= sh[1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STOP_BIT: begin
          if (bit_end) begin
            cnt <= '0;
            st  <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: sends a word as NUM_BYTES back-to-back 8N1 frames,
// LSB byte first, with a one-clock gap between frames.
module uart_word_tx
  import uart_word_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_BYTES    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        done,
  output logic        uart_tx
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_BYTES - 1);

  word_state_e st;
  logic [23:0] word_q;
  logic [1:0]  byte_idx;
  logic        byte_start;
  logic [7:0]  byte_data;
  logic        byte_busy;
  logic        byte_done;

  // First byte goes straight from data_in so the start bit begins
  // on the cycle after acceptance; later bytes come from word_q.
  assign byte_start = !byte_busy &&
                      (((st == W_IDLE) && start) || (st == W_NEXT));
  assign byte_data  = (st == W_IDLE) ? data_in[7:0] : word_q[7:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= W_IDLE;
      word_q   <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st)
        W_IDLE: begin
          if (start && !byte_busy) begin
            word_q   <= data_in[31:8];
            byte_idx <= '0;
            busy     <= 1'b1;
            st       <= W_SEND;
          end
        end
        W_SEND: begin
          if (byte_done) begin
            if (byte_idx == LAST_IDX) begin
              busy <= 1'b0;
              done <= 1'b1;
              st   <= W_IDLE;
            end else begin
              st <= W_NEXT;
            end
          end
        end
        W_NEXT: begin
          word_q   <= word_q >> 8;
          byte_idx <= byte_idx + 2'd1;
          st       <= W_SEND;
        end
        default: st <= W_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .rst_n     (reset),
    .byte_start(byte_start),
    .byte_data (byte_data),
    .byte_busy (byte_busy),
    .byte_done (byte_done),
    .tx        (uart_tx)
  );

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: per-cycle line/busy/done model plus a UART
// receiver that decodes the captured line trace.
module tb_uart_word_tx;

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } exp_t;
  typedef exp_t expq_t[$];
  typedef logic bitq_t[$];

  localparam exp_t IDLE_E = 3'b100;

  logic        clk;
  logic        r0, r1;
  logic        start0, start1;
  logic [31:0] data0, data1;
  logic        busy0, done0, tx0;
  logic        busy1, done1, tx1;

  int checks   = 0;
  int failures = 0;

  expq_t eq0, eq1;
  bitq_t tr0, bt0, dn0, tr1, bt1, dn1;

  uart_word_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(4)) dut0 (
    .clk(clk), .reset(r0), .start(start0), .data_in(data0),
    .busy(busy0), .done(done0), .uart_tx(tx0)
  );

  uart_word_tx #(.CLKS_PER_BIT(2), .NUM_BYTES(1)) dut1 (
    .clk(clk), .reset(r1), .start(start1), .data_in(data1),
    .busy(busy1), .done(done1), .uart_tx(tx1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Expected per-cycle (tx,busy,done) from acceptance+1 to the done cycle.
  function automatic expq_t build(input logic [31:0] w, input int cpb,
                                  input int nb);
    expq_t q;
    logic [7:0] by;
    logic lv;
    for (int b = 0; b < nb; b++) begin
      by = w[8*b +: 8];
      for (int k = 0; k < 10; k++) begin
        lv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : by[k-1];
        for (int c = 0; c < cpb; c++) q.push_back({lv, 1'b1, 1'b0});
      end
      if (b < nb - 1) q.push_back(3'b110);
    end
    q.push_back(3'b101);
    return q;
  endfunction

  function automatic int count1(input bitq_t q, input int base);
    int n = 0;
    for (int i = base; i < q.size(); i++) if (q[i] === 1'b1) n++;
    return n;
  endfunction

  // Mid-bit sampling receiver over a captured line trace.
  function automatic logic [31:0] rx_decode(input bitq_t tr, input int base,
                                            input int cpb, input int nb,
                                            output logic ok);
    logic [31:0] w = '0;
    int i = base;
    logic lv;
    ok = 1'b1;
    for (int b = 0; b < nb; b++) begin
      while (i < tr.size() && tr[i] !== 1'b0) i++;
      if (i + 10*cpb > tr.size()) begin
        ok = 1'b0;
        return w;
      end
      for (int k = 0; k < 10; k++) begin
        lv = tr[i + k*cpb + cpb/2];
        if (k == 0) begin
          if (lv !== 1'b0) ok = 1'b0;
        end else if (k == 9) begin
          if (lv !== 1'b1) ok = 1'b0;
        end else begin
          w[8*b + k - 1] = lv;
        end
      end
      i += 10*cpb;
    end
    return w;
  endfunction

  always @(negedge clk) begin : chk0
    exp_t e;
    expq_t nq;
    e = IDLE_E;
    if (!r0) eq0.delete();
    else if (eq0.size() > 0) e = eq0.pop_front();
    check("line0", {29'd0, tx0, busy0, done0}, {29'd0, e});
    tr0.push_back(tx0);
    bt0.push_back(busy0);
    dn0.push_back(done0);
    if (r0 && start0 && !e.busy) begin
      nq = build(data0, 4, 4);
      foreach (nq[i]) eq0.push_back(nq[i]);
    end
  end

  always @(negedge clk) begin : chk1
    exp_t e;
    expq_t nq;
    e = IDLE_E;
    if (!r1) eq1.delete();
    else if (eq1.size() > 0) e = eq1.pop_front();
    check("line1", {29'd0, tx1, busy1, done1}, {29'd0, e});
    tr1.push_back(tx1);
    bt1.push_back(busy1);
    dn1.push_back(done1);
    if (r1 && start1 && !e.busy) begin
      nq = build(data1, 2, 1);
      foreach (nq[i]) eq1.push_back(nq[i]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int which, input int lim);
    int n = 0;
    while (((which == 0) ? eq0.size() : eq1.size()) > 0 && n < lim) begin
      step();
      n++;
    end
    check("idle_timeout", (n < lim) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic send0(input logic [31:0] w);
    start0 = 1'b1;
    data0  = w;
    step();
    start0 = 1'b0;
    data0  = $urandom;
  endtask

  initial begin
    int base, b2;
    logic [31:0] w, x;
    logic ok;
    r0 = 1'b0; r1 = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    data0 = '0; data1 = '0;
    repeat (3) step();
    r0 = 1'b1; r1 = 1'b1;

    base = tr0.size();
    repeat (50) step();
    check("idle_tx_high", count1(tr0, base), 50);
    check("idle_busy", count1(bt0, base), 0);
    check("idle_done", count1(dn0, base), 0);

    base = tr0.size();
    send0(32'hA55A0F31);
    wait_idle(0, 400);
    w = rx_decode(tr0, base, 4, 4, ok);
    check("rx_a", w, 32'hA55A0F31);
    check("rx_a_ok", {31'd0, ok}, 1);
    check("busy_a", count1(bt0, base), 163);
    check("done_a", count1(dn0, base), 1);

    base = tr0.size();
    start0 = 1'b1;
    data0  = 32'hA55A0F31;
    step();
    repeat (160) begin
      data0 = $urandom;
      step();
    end
    start0 = 1'b0;
    wait_idle(0, 400);
    w = rx_decode(tr0, base, 4, 4, ok);
    check("rx_spam", w, 32'hA55A0F31);
    check("busy_spam", count1(bt0, base), 163);
    check("done_spam", count1(dn0, base), 1);

    x = $urandom;
    base = tr0.size();
    send0(x);
    repeat (163) step();
    check("done_b2b", {31'd0, done0}, 1);
    b2 = tr0.size();
    start0 = 1'b1;
    data0  = 32'h0;
    step();
    start0 = 1'b0;
    data0  = $urandom;
    wait_idle(0, 400);
    w = rx_decode(tr0, base, 4, 4, ok);
    check("rx_b2b_first", w, x);
    w = rx_decode(tr0, b2, 4, 4, ok);
    check("rx_b2b_zero", w, 32'h0);
    check("rx_b2b_ok", {31'd0, ok}, 1);
    check("b2b_done_tx", {31'd0, tr0[b2]}, 1);
    check("b2b_no_gap", {31'd0, tr0[b2+1]}, 0);

    repeat (1500) begin
      start0 = ($urandom_range(0, 15) == 0);
      data0  = $urandom;
      step();
    end
    start0 = 1'b0;
    wait_idle(0, 400);

    send0(32'h0);
    repeat (60) step();
    @(posedge clk);
    #3;
    check("pre_rst_tx", {31'd0, tx0}, 0);
    check("pre_rst_busy", {31'd0, busy0}, 1);
    r0 = 1'b0;
    #1;
    check("rst_tx", {31'd0, tx0}, 1);
    check("rst_busy", {31'd0, busy0}, 0);
    check("rst_done", {31'd0, done0}, 0);
    repeat (3) step();
    r0 = 1'b1;
    base = tr0.size();
    repeat (20) step();
    check("post_rst_quiet", count1(tr0, base), 20);
    base = tr0.size();
    send0(32'hFFFFFFFF);
    wait_idle(0, 400);
    w = rx_decode(tr0, base, 4, 4, ok);
    check("rx_ff", w, 32'hFFFFFFFF);
    check("busy_ff", count1(bt0, base), 163);

    base = tr1.size();
    start1 = 1'b1;
    data1  = 32'h12345680;
    step();
    start1 = 1'b0;
    data1  = $urandom;
    wait_idle(1, 100);
    repeat (10) step();
    w = rx_decode(tr1, base, 2, 1, ok);
    check("rx_nb1", w, 32'h80);
    check("busy_nb1", count1(bt1, base), 20);
    check("done_nb1", count1(dn1, base), 1);
    check("zeros_nb1", tr1.size() - base - count1(tr1, base), 16);

    repeat (400) begin
      start1 = ($urandom_range(0, 7) == 0);
      data1  = $urandom;
      step();
    end
    start1 = 1'b0;
    wait_idle(1, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
